sseg_scan_ctrl: RTL and testbench
=================================

SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles each digit is held (>=2).
REQ-002 SHALL have parameter GUARD, default 4, number of blanking cycles at the start of each digit slot (<REFRESH_DIV).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port load, input, 1, one-cycle strobe that captures value, dp_mask and digit_en.
REQ-006 SHALL have port value, input, 32, eight hex nibbles; nibble k (bits 4k+3:4k) belongs to digit k.
REQ-007 SHALL have port dp_mask, input, 8, bit k=1 lights the decimal point of digit k.
REQ-008 SHALL have port digit_en, input, 8, bit k=0 blanks digit k.
REQ-009 SHALL have port active, output, 3, index of the digit currently driven, fed to the single-digit driver's select.
REQ-010 SHALL have port num, output, 4, hex nibble for the current digit.
REQ-011 SHALL have port dp_ctrl, output, 1, decimal point, active-low (0 = lit).
REQ-012 SHALL have port blank, output, 1, high = all anodes must be disabled this cycle.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse when the scan wraps from digit 7 to digit 0.
REQ-014 SHALL have port load_pending, output, 1, high while captured data awaits application.

Function
REQ-015 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; tick SHALL be asserted in the cycle the count equals REFRESH_DIV-1.
REQ-016 On tick, active SHALL advance by one modulo 8 (7 wraps to 0); active changes only on tick.
REQ-017 frame_done SHALL pulse high for exactly the one cycle after a tick taken while active==7, aligned with active becoming 0.
REQ-018 load SHALL copy value/dp_mask/digit_en into pending registers and set load_pending; of several loads before one frame boundary, the last one wins.
REQ-019 At a frame boundary (tick with active==7), pending contents SHALL transfer to the display registers and load_pending SHALL clear; data therefore never changes mid-frame.
REQ-020 If load coincides with a frame boundary, the incoming inputs SHALL transfer directly to the display registers and load_pending SHALL end low.
REQ-021 num SHALL equal the display-register nibble for the current active value, updated in the same cycle active changes.
REQ-022 blank SHALL be high for the first GUARD cycles of every digit slot (prescaler count < GUARD), and for the whole slot when the displayed digit_en bit is 0.
REQ-023 dp_ctrl SHALL equal the inverse of the displayed dp_mask bit for the current digit, and SHALL be 1 whenever blank is high.
REQ-024 All outputs SHALL be registered; there is no combinational path from any input to any output.

Reset
REQ-025 While reset_n is low: active=0, num=0, dp_ctrl=1, blank=1, frame_done=0, load_pending=0, prescaler=0, pending and display registers all zero.
REQ-026 Reset asserted mid-frame SHALL discard pending data; after release, scanning SHALL restart at digit 0 with a full GUARD interval.

Structure
REQ-027 Package sseg_pkg SHALL hold NUM_DIGITS=8, IDX_W=3, NIBBLE_W=4 and the default REFRESH_DIV/GUARD constants.
REQ-028 The prescaler SHALL be a sub-module named tick_gen (parameter DIV; ports clk, reset_n, tick, count).

Verification (REFRESH_DIV=4, GUARD=1)
REQ-029 Reset released, no load -> active steps 0..7 every 4 cycles, num=0, blank=1 throughout (digit_en=0), dp_ctrl=1.
REQ-030 Load value=32'h89ABCDEF, dp_mask=8'h01, digit_en=8'hFF mid-frame -> load_pending=1 until the wrap; next frame shows num F,E,D,C,B,A,9,8 for digits 0..7, dp_ctrl=0 only on digit 0 after its guard cycle.
REQ-031 Two loads (32'h11111111, then 32'h22222222) within one frame -> next frame shows only 2s; load_pending clears at the boundary.
REQ-032 Load 32'h12345678 in the exact cycle of the 7->0 tick -> digit 0 of the immediately following frame shows 8; load_pending stays 0; frame_done pulses once.
REQ-033 digit_en=8'h0F -> digits 4..7 have blank=1 for all 4 cycles; digits 0..3 have blank=1 only in the first cycle.
REQ-034 reset_n pulsed low while active=5 with load_pending=1 -> all outputs at reset values; after release, active=0, load_pending=0, display shows zeros blanked.

Source files
------------

// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants, types and helpers for the seven-segment scan controller
package sseg_pkg;

  localparam int NUM_DIGITS      = 8;
  localparam int IDX_W           = 3;
  localparam int NIBBLE_W        = 4;
  localparam int DEF_REFRESH_DIV = 100000;
  localparam int DEF_GUARD       = 4;

  // One complete display image: hex nibbles, decimal points, digit enables
  typedef struct packed {
    logic [NUM_DIGITS*NIBBLE_W-1:0] value;
    logic [NUM_DIGITS-1:0]          dp;
    logic [NUM_DIGITS-1:0]          en;
  } disp_data_t;

  function automatic logic [NIBBLE_W-1:0] get_nibble(
    input logic [NUM_DIGITS*NIBBLE_W-1:0] v,
    input logic [IDX_W-1:0]               idx
  );
    return v[{idx, 2'b00} +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler producing one tick every DIV cycles
module tick_gen
  import sseg_pkg::*;
#(
  parameter int  DIV = DEF_REFRESH_DIV,
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic          tick,
  output logic [CW-1:0] count
);

  // Tick marks the last cycle of each period so the consumer can advance on the same edge the count wraps
  always_comb begin
    tick = (count == CW'(DIV - 1));
  end

  // Count 0..DIV-1 and wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// rtl/sseg_scan_ctrl.sv - multiplexed eight-digit scan controller with frame-aligned data update
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int GUARD       = DEF_GUARD
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           load,
  input  logic [NUM_DIGITS*NIBBLE_W-1:0] value,
  input  logic [NUM_DIGITS-1:0]          dp_mask,
  input  logic [NUM_DIGITS-1:0]          digit_en,
  output logic [IDX_W-1:0]               active,
  output logic [NIBBLE_W-1:0]            num,
  output logic                           dp_ctrl,
  output logic                           blank,
  output logic                           frame_done,
  output logic                           load_pending
);

  localparam int            CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  logic             tick;
  logic [CW-1:0]    count;
  logic [CW-1:0]    cnt_next;
  logic [IDX_W-1:0] act_next;
  logic             boundary;
  logic             blank_next;
  disp_data_t       in_d;
  disp_data_t       pend_q;
  disp_data_t       disp_q;
  disp_data_t       disp_next;

  tick_gen #(
    .DIV(REFRESH_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .tick   (tick),
    .count  (count)
  );

  // Outputs are registered from next-state values so they line up with the prescaler and digit index they describe
  always_comb begin
    in_d.value = value;
    in_d.dp    = dp_mask;
    in_d.en    = digit_en;
    boundary   = tick && (active == IDX_W'(NUM_DIGITS - 1));
    cnt_next   = tick ? '0 : count + 1'b1;
    act_next   = tick ? active + 1'b1 : active;
    disp_next  = disp_q;
    if (boundary) begin
      if (load) begin
        disp_next = in_d;
      end else if (load_pending) begin
        disp_next = pend_q;
      end
    end
    blank_next = (cnt_next < GUARD_C) || !disp_next.en[act_next];
  end

  // Scan state, frame-aligned data handoff and registered display outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active       <= '0;
      num          <= '0;
      dp_ctrl      <= 1'b1;
      blank        <= 1'b1;
      frame_done   <= 1'b0;
      load_pending <= 1'b0;
      pend_q       <= '0;
      disp_q       <= '0;
    end else begin
      active     <= act_next;
      frame_done <= boundary;
      disp_q     <= disp_next;
      // Pending always tracks the newest load so a later boundary never resurrects stale data
      if (load) begin
        pend_q <= in_d;
      end
      if (boundary) begin
        load_pending <= 1'b0;
      end else if (load) begin
        load_pending <= 1'b1;
      end
      num     <= get_nibble(disp_next.value, act_next);
      blank   <= blank_next;
      dp_ctrl <= blank_next | ~disp_next.dp[act_next];
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb/tb_sseg_scan_ctrl.sv - directed self-checking bench for sseg_scan_ctrl
module tb_sseg_scan_ctrl;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic [7:0]  digit_en;
  logic [2:0]  active;
  logic [3:0]  num;
  logic        dp_ctrl;
  logic        blank;
  logic        frame_done;
  logic        load_pending;

  int total = 0;
  int bad   = 0;
  int k     = 0;

  sseg_scan_ctrl #(
    .REFRESH_DIV(4),
    .GUARD      (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .value       (value),
    .dp_mask     (dp_mask),
    .digit_en    (digit_en),
    .active      (active),
    .num         (num),
    .dp_ctrl     (dp_ctrl),
    .blank       (blank),
    .frame_done  (frame_done),
    .load_pending(load_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    k += n;
  endtask

  task automatic do_load(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] en);
    value    = v;
    dp_mask  = dp;
    digit_en = en;
    load     = 1'b1;
    cyc(1);
    load     = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_active"}, 32'(active), 32'd0);
    chk({tag, "_num"}, 32'(num), 32'd0);
    chk({tag, "_dp"}, 32'(dp_ctrl), 32'd1);
    chk({tag, "_blank"}, 32'(blank), 32'd1);
    chk({tag, "_fd"}, 32'(frame_done), 32'd0);
    chk({tag, "_lp"}, 32'(load_pending), 32'd0);
  endtask

  // Checks n consecutive cycles against a display image; k is cycles since reset release
  task automatic check_frame(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] en, input int n);
    int          d;
    int          c;
    logic        blank_e;
    logic        dp_e;
    logic        fd_e;
    logic [31:0] sh;
    for (int i = 0; i < n; i++) begin
      d       = (k % 32) / 4;
      c       = k % 4;
      blank_e = (c == 0) || !en[d];
      dp_e    = blank_e ? 1'b1 : !dp[d];
      fd_e    = (k % 32 == 0) && (k != 0);
      sh      = v >> (4 * d);
      chk("active", 32'(active), 32'(d));
      chk("num", 32'(num), 32'(sh[3:0]));
      chk("blank", 32'(blank), 32'(blank_e));
      chk("dp_ctrl", 32'(dp_ctrl), 32'(dp_e));
      chk("frame_done", 32'(frame_done), 32'(fd_e));
      cyc(1);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    load     = 1'b0;
    value    = '0;
    dp_mask  = '0;
    digit_en = '0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    reset_n = 1'b1;
    k = 0;

    // Idle scan with everything blanked
    check_frame(32'h0, 8'h00, 8'h00, 40);

    // Mid-frame load is held until the wrap
    do_load(32'h89ABCDEF, 8'h01, 8'hFF);
    chk("lp_after_load", 32'(load_pending), 32'd1);
    check_frame(32'h0, 8'h00, 8'h00, 22);
    chk("lp_before_wrap", 32'(load_pending), 32'd1);
    check_frame(32'h0, 8'h00, 8'h00, 1);
    chk("lp_after_wrap", 32'(load_pending), 32'd0);
    check_frame(32'h89ABCDEF, 8'h01, 8'hFF, 36);

    // Two loads in one frame: last wins
    do_load(32'h11111111, 8'h00, 8'hFF);
    chk("lp_first", 32'(load_pending), 32'd1);
    check_frame(32'h89ABCDEF, 8'h01, 8'hFF, 7);
    do_load(32'h22222222, 8'h00, 8'hFF);
    check_frame(32'h89ABCDEF, 8'h01, 8'hFF, 18);
    chk("lp_two_loads", 32'(load_pending), 32'd1);
    check_frame(32'h89ABCDEF, 8'h01, 8'hFF, 1);
    chk("lp_two_clear", 32'(load_pending), 32'd0);
    check_frame(32'h22222222, 8'h00, 8'hFF, 31);

    // Load coinciding with the 7->0 tick goes straight to the display
    chk("coinc_active7", 32'(active), 32'd7);
    do_load(32'h12345678, 8'h00, 8'hFF);
    chk("coinc_num", 32'(num), 32'h8);
    chk("coinc_lp", 32'(load_pending), 32'd0);
    check_frame(32'h12345678, 8'h00, 8'hFF, 40);

    // Upper four digits disabled
    do_load(32'h12345678, 8'h00, 8'h0F);
    check_frame(32'h12345678, 8'h00, 8'hFF, 23);
    check_frame(32'h12345678, 8'h00, 8'h0F, 20);

    // Reset mid-frame with a load pending
    do_load(32'hAAAAAAAA, 8'hFF, 8'hFF);
    chk("pre_rst_lp", 32'(load_pending), 32'd1);
    chk("pre_rst_active", 32'(active), 32'd5);
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    chk_reset_outputs("held_rst");
    reset_n = 1'b1;
    k = 0;
    check_frame(32'h0, 8'h00, 8'h00, 40);
    chk("post_rst_lp", 32'(load_pending), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
